// File: rtl/adam_aes_key_expansion_reverse.sv
// rtl/adam_aes_key_expansion_reverse.sv - inverse AES-128 key schedule, RK[10] back to RK[0], one round per cycle
module adam_aes_key_expansion_reverse (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] last_key,
    input  logic         init,
    output logic [127:0] round_keys [0:10],
    output logic         ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    logic [1:0]   state;
    logic [3:0]   counter;
    logic [127:0] cur_key;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [127:0] next_key;

    // Mux out RK[counter]; only indices 0..10 exist, anything else reads zero.
    always_comb begin
        cur_key = '0;
        for (int k = 0; k < 11; k++) begin
            if (counter == k[3:0]) cur_key = round_keys[k];
        end
    end

    assign {w0, w1, w2, w3} = cur_key;
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign rot_word = {p3[23:0], p3[31:24]};
    assign sub_word = {SBOX[rot_word[31:24]], SBOX[rot_word[23:16]],
                       SBOX[rot_word[15:8]],  SBOX[rot_word[7:0]]};
    assign p0 = w0 ^ sub_word ^ {rcon(counter), 24'h0};
    assign next_key = {p0, p1, p2, p3};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 11; k++) round_keys[k] <= '0;
            ready   <= 1'b0;
            state   <= ST_IDLE;
            counter <= 4'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (init) begin
                        for (int k = 0; k < 10; k++) round_keys[k] <= '0;
                        round_keys[10] <= last_key;
                        counter        <= 4'd10;
                        ready          <= 1'b0;
                        state          <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // init is deliberately ignored here: a running schedule is never restarted.
                    round_keys[counter - 4'd1] <= next_key;
                    counter                    <= counter - 4'd1;
                    if (counter == 4'd1) begin
                        state <= ST_DONE;
                        ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adam_aes_key_expansion_reverse.sv
// tb/tb_adam_aes_key_expansion_reverse.sv - randomized bench for the inverse AES-128 key schedule
module tb_adam_aes_key_expansion_reverse;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] last_key;
    logic         init;
    logic [127:0] rk [0:10];
    logic         ready;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_rk [0:10];
    logic [127:0] fwd_rk [0:10];

    adam_aes_key_expansion_reverse dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .last_key   (last_key),
        .init       (init),
        .round_keys (rk),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%032h expected=%032h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // S-box from first principles: multiplicative inverse in GF(2^8) then the affine map.
    function automatic logic [7:0] sbox_math(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        if (a == 8'h00) inv = 8'h00;
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] g_func(input logic [31:0] w, input int rnd);
        logic [31:0] r = {w[23:0], w[31:24]};
        logic [7:0]  rc = 8'h01;
        for (int i = 1; i < rnd; i++) rc = xtime(rc);
        return {sbox_math(r[31:24]) ^ rc, sbox_math(r[23:16]), sbox_math(r[15:8]), sbox_math(r[7:0])};
    endfunction

    // Word-array inverse recurrence: w[i-4] = w[i] ^ (i%4==0 ? g(w[i-1]) : w[i-1]).
    task automatic model_reverse(input logic [127:0] k);
        logic [31:0] w [0:43];
        {w[40], w[41], w[42], w[43]} = k;
        for (int i = 43; i >= 4; i--) begin
            if (i % 4 == 0) w[i-4] = w[i] ^ g_func(w[i-1], i / 4);
            else            w[i-4] = w[i] ^ w[i-1];
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_forward(input logic [127:0] k);
        logic [31:0] w [0:43];
        {w[0], w[1], w[2], w[3]} = k;
        for (int i = 4; i < 44; i++) begin
            if (i % 4 == 0) w[i] = w[i-4] ^ g_func(w[i-1], i / 4);
            else            w[i] = w[i-4] ^ w[i-1];
        end
        for (int r = 0; r < 11; r++) fwd_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] or_keys(input int lo, input int hi);
        logic [127:0] acc = '0;
        for (int i = lo; i <= hi; i++) acc = acc | rk[i];
        return acc;
    endfunction

    // Called at a negedge; ends at the negedge after the 11th posedge, checking ready timing.
    task automatic run_schedule(input logic [127:0] key, input string tag);
        last_key = key;
        init     = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check_eq({tag, "_ready_low_after_init"}, {127'b0, ready}, 128'd0);
        repeat (9) @(negedge clk);
        check_eq({tag, "_ready_edge10"}, {127'b0, ready}, 128'd0);
        @(negedge clk);
        check_eq({tag, "_ready_edge11"}, {127'b0, ready}, 128'd1);
    endtask

    task automatic compare_all(input string tag);
        for (int r = 0; r < 11; r++) check_eq($sformatf("%s_rk%0d", tag, r), rk[r], exp_rk[r]);
    endtask

    logic [127:0] a1_key;
    logic [127:0] key;

    initial begin
        a1_key   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        reset_n  = 1'b0;
        init     = 1'b0;
        last_key = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_ready", {127'b0, ready}, 128'd0);
        check_eq("reset_keys", or_keys(0, 10), 128'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1
        run_schedule(a1_key, "a1");
        model_reverse(a1_key);
        compare_all("a1");
        check_eq("a1_kat_rk0", rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check_eq("a1_kat_rk1", rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("a1_kat_rk9", rk[9], 128'hac7766f319fadc2128d12941575c006e);
        check_eq("a1_kat_rk10", rk[10], a1_key);
        model_forward(rk[0]);
        for (int r = 0; r < 11; r++) check_eq($sformatf("roundtrip_rk%0d", r), rk[r], fwd_rk[r]);
        repeat (3) @(negedge clk);
        check_eq("done_hold_ready", {127'b0, ready}, 128'd1);
        check_eq("done_hold_rk0", rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // FIPS-197 C.1
        run_schedule(128'h13111d7fe3944a17f307a78b4d2b30c5, "c1");
        check_eq("c1_kat_rk0", rk[0], 128'h000102030405060708090a0b0c0d0e0f);

        // Randomized keys, with last_key disturbed after the init edge
        for (int t = 0; t < 4; t++) begin
            key      = {$urandom, $urandom, $urandom, $urandom};
            last_key = key;
            init     = 1'b1;
            @(negedge clk);
            init     = 1'b0;
            last_key = ~key;
            repeat (10) @(negedge clk);
            check_eq($sformatf("rand%0d_ready", t), {127'b0, ready}, 128'd1);
            model_reverse(key);
            compare_all($sformatf("rand%0d", t));
        end

        // init re-pulsed at BUSY cycle 4 is ignored
        last_key = a1_key;
        init     = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (3) @(negedge clk);
        last_key = {$urandom, $urandom, $urandom, $urandom};
        init     = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("reinit_ready_edge10", {127'b0, ready}, 128'd0);
        @(negedge clk);
        check_eq("reinit_ready_edge11", {127'b0, ready}, 128'd1);
        model_reverse(a1_key);
        compare_all("reinit");

        // Asynchronous reset mid-BUSY
        key      = {$urandom, $urandom, $urandom, $urandom};
        last_key = key;
        init     = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("midreset_ready", {127'b0, ready}, 128'd0);
        check_eq("midreset_keys", or_keys(0, 10), 128'd0);
        repeat (2) @(negedge clk);
        check_eq("midreset_held_keys", or_keys(0, 10), 128'd0);
        reset_n = 1'b1;
        @(negedge clk);
        key = {$urandom, $urandom, $urandom, $urandom};
        run_schedule(key, "post_reset");
        model_reverse(key);
        compare_all("post_reset");

        // From DONE, last_key = 0
        last_key = '0;
        init     = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check_eq("zero_ready_drop", {127'b0, ready}, 128'd0);
        check_eq("zero_cleared_rk0_9", or_keys(0, 9), 128'd0);
        repeat (10) @(negedge clk);
        check_eq("zero_ready", {127'b0, ready}, 128'd1);
        check_eq("zero_rk10", rk[10], 128'd0);
        check_eq("zero_rk9_nonzero", {127'b0, (rk[9] != 128'd0)}, 128'd1);
        model_reverse(128'd0);
        compare_all("zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
